// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: state encodings,
// opcode constants, alu_op codes and datapath select codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Wait counter width; covers MEM_WAIT_CYCLES up to 7.
    localparam int unsigned WaitW = 3;

    // States that touch memory and are stretched by the wait counter.
    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait counter for the multicycle control FSM.
// clear_i forces the count to zero, otherwise en_i increments it. done_o is
// high while the count equals MaxCount, i.e. on the last cycle of a hold.
// Ports: clk_i clock, reset_i sync active-high reset, clear_i, en_i, done_o.
module mc_wait_counter
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MaxCount = 0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    logic [WaitW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == WaitW'(MaxCount));

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath
// strobe and select as a Moore decode of the state (and wait counter).
// Optional feature: define MC_ADDI_EN to build the addi path (ADDIEX, ADDIWB);
// without it opcode 001000 is reported as illegal.
// Ports: clk, reset (sync, active high), opcode (IR[31:26]); outputs alu_op,
// alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, i_or_d, mem_read,
// mem_write, ir_write, mem_to_reg, reg_dst, reg_write, state (debug),
// instr_done (last cycle of each instruction), illegal_op (bad opcode in DECODE).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e state_q, state_d;
    logic   store_q;   // lw/sw choice captured in DECODE; opcode is ignored afterwards
    logic   in_mem;
    logic   wait_done;

    assign in_mem = is_mem_state(state_q);
    assign state  = state_q;

    // Counter restarts whenever a hold finishes or we are outside a memory state,
    // so it is always zero on entry to the next memory state.
    mc_wait_counter #(
        .MaxCount(MEM_WAIT_CYCLES)
    ) u_wait (
        .clk_i  (clk),
        .reset_i(reset),
        .clear_i(!in_mem || wait_done),
        .en_i   (in_mem),
        .done_o (wait_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                store_q <= (opcode == OP_SW);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_op        = ALUOP_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (wait_done) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SRCB_IMM_SHL2;
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_J:         state_d = StJump;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = StAddiEx;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = store_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (wait_done) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (wait_done) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = StRwb;
            end
            StRwb: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = StFetch;
            end
            StJump: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
`ifdef MC_ADDI_EN
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
`endif
            default: state_d = StFetch;
        endcase

        // Reset may arrive in any state; keep the datapath quiet while it is held.
        if (reset) begin
            alu_op        = ALUOP_ADD;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_REGB;
            pc_source     = PCSRC_ALU;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            instr_done    = 1'b0;
            illegal_op    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances with MEM_WAIT_CYCLES 0, 2 and 3.
// Only one instance runs at a time; the others are held in reset. Each
// instruction is expanded into its expected per-cycle output sequence.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       done;
        logic       ill;
    } ov_t;

    localparam logic [21:0] MaskAll  = 22'h3fffff;
    localparam logic [21:0] MaskNoSt = 22'h03ffff;

    logic       clk;
    logic [2:0] rst;
    logic [5:0] op  [3];
    ov_t        obs [3];

    int n_checks;
    int n_errors;

    ov_t         exp_q[$];
    int unsigned waits[3] = '{0, 2, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 0 : g + 1;
        logic [1:0] alu_op, alu_src_b, pc_source;
        logic [3:0] state;
        logic alu_src_a, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
        logic ir_write, mem_to_reg, reg_dst, reg_write, instr_done, illegal_op;

        multicycle_control #(
            .MEM_WAIT_CYCLES(W)
        ) u_dut (
            .clk          (clk),
            .reset        (rst[g]),
            .opcode       (op[g]),
            .alu_op       (alu_op),
            .alu_src_a    (alu_src_a),
            .alu_src_b    (alu_src_b),
            .pc_source    (pc_source),
            .pc_write     (pc_write),
            .pc_write_cond(pc_write_cond),
            .i_or_d       (i_or_d),
            .mem_read     (mem_read),
            .mem_write    (mem_write),
            .ir_write     (ir_write),
            .mem_to_reg   (mem_to_reg),
            .reg_dst      (reg_dst),
            .reg_write    (reg_write),
            .state        (state),
            .instr_done   (instr_done),
            .illegal_op   (illegal_op)
        );

        assign obs[g] = {state, alu_op, alu_src_a, alu_src_b, pc_source, pc_write,
                         pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_dst, reg_write, instr_done, illegal_op};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Expected cycle-by-cycle outputs of one instruction, from the instruction's
    // phase list: fetch held w+1 cycles, decode, then the opcode's own phases.
    task automatic plan(input logic [5:0] opc, input int unsigned w);
        ov_t v;
        logic legal;
        exp_q.delete();
        for (int i = 0; i <= int'(w); i++) begin
            v = '0; v.st = 4'd0; v.mrd = 1'b1; v.srcb = 2'b01;
            if (i == int'(w)) begin v.irw = 1'b1; v.pcw = 1'b1; end
            exp_q.push_back(v);
        end
        legal = (opc == 6'b100011) || (opc == 6'b101011) || (opc == 6'b000000) ||
                (opc == 6'b000100) || (opc == 6'b000010);
`ifdef MC_ADDI_EN
        if (opc == 6'b001000) legal = 1'b1;
`endif
        v = '0; v.st = 4'd1; v.srcb = 2'b11; v.ill = !legal;
        exp_q.push_back(v);
        if (!legal) return;
        if (opc == 6'b100011 || opc == 6'b101011) begin
            v = '0; v.st = 4'd2; v.srca = 1'b1; v.srcb = 2'b10;
            exp_q.push_back(v);
            for (int i = 0; i <= int'(w); i++) begin
                v = '0; v.iord = 1'b1;
                if (opc == 6'b100011) begin
                    v.st = 4'd3; v.mrd = 1'b1;
                end else begin
                    v.st = 4'd5; v.mwr = 1'b1; v.done = (i == int'(w));
                end
                exp_q.push_back(v);
            end
            if (opc == 6'b100011) begin
                v = '0; v.st = 4'd4; v.rw = 1'b1; v.m2r = 1'b1; v.done = 1'b1;
                exp_q.push_back(v);
            end
        end else if (opc == 6'b000000) begin
            v = '0; v.st = 4'd6; v.srca = 1'b1; v.aluop = 2'b10;
            exp_q.push_back(v);
            v = '0; v.st = 4'd7; v.rw = 1'b1; v.rdst = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (opc == 6'b000100) begin
            v = '0; v.st = 4'd8; v.srca = 1'b1; v.aluop = 2'b01; v.pcwc = 1'b1;
            v.pcsrc = 2'b01; v.done = 1'b1;
            exp_q.push_back(v);
        end else if (opc == 6'b000010) begin
            v = '0; v.st = 4'd9; v.pcw = 1'b1; v.pcsrc = 2'b10; v.done = 1'b1;
            exp_q.push_back(v);
        end else begin
            v = '0; v.st = 4'd10; v.srca = 1'b1; v.srcb = 2'b10;
            exp_q.push_back(v);
            v = '0; v.st = 4'd11; v.rw = 1'b1; v.done = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample shortly after.
    task automatic drive(input int k, input logic r, input logic [5:0] opc, input ov_t e,
                         input logic [21:0] mask, input string tag);
        @(negedge clk);
        rst[k] = r;
        op[k]  = opc;
        #2;
        check_eq(tag, 32'(obs[k] & mask), 32'(e & mask));
    endtask

    // Runs plan entries [0, stop) of the current plan; opcode is junk except in DECODE.
    task automatic run_plan(input int k, input logic [5:0] opc, input int stop);
        int dec_idx;
        dec_idx = int'(waits[k]) + 1;
        for (int i = 0; i < stop; i++) begin
            drive(k, 1'b0, (i == dec_idx) ? opc : 6'($urandom), exp_q[i], MaskAll,
                  $sformatf("dut%0d op%b cyc%0d", k, opc, i));
        end
    endtask

    task automatic run_instr(input int k, input logic [5:0] opc);
        plan(opc, waits[k]);
        run_plan(k, opc, exp_q.size());
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] pool [6];
        int sel;
        pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        sel = int'($urandom_range(0, 7));
        if (sel < 6) return pool[sel];
        return 6'($urandom);
    endfunction

    initial begin
        logic [5:0] directed [7];
        directed = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                     6'b111111, 6'b001000};
        n_checks = 0;
        n_errors = 0;
        rst = 3'b111;
        for (int k = 0; k < 3; k++) op[k] = 6'd0;

        // Instance 0: no wait states.
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 6'($urandom), '0, MaskAll, "dut0 reset");
        for (int i = 0; i < 7; i++) run_instr(0, directed[i]);
        for (int i = 0; i < 40; i++) run_instr(0, rand_op());
        rst[0] = 1'b1;

        // Instance 1: two wait cycles per memory state.
        for (int i = 0; i < 2; i++) drive(1, 1'b1, 6'($urandom), '0, MaskAll, "dut1 reset");
        run_instr(1, 6'b101011);
        run_instr(1, 6'b100011);
        run_instr(1, 6'b000000);
        for (int i = 0; i < 15; i++) run_instr(1, rand_op());
        rst[1] = 1'b1;

        // Instance 2: reset lands on the second MEMRD hold cycle of a lw.
        for (int i = 0; i < 2; i++) drive(2, 1'b1, 6'($urandom), '0, MaskAll, "dut2 reset");
        plan(6'b100011, waits[2]);
        run_plan(2, 6'b100011, 7);
        for (int i = 0; i < 2; i++) begin
            drive(2, 1'b1, 6'($urandom), '0, MaskNoSt, $sformatf("dut2 midreset%0d", i));
        end
        run_instr(2, 6'b100011);
        for (int i = 0; i < 10; i++) run_instr(2, rand_op());
        rst[2] = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It is the upstream end of the ALUOp interface: it generates the 2-bit alu_op consumed by the ALU control decoder, plus every datapath strobe and mux select. It sequences instructions through fetch, decode, execute, memory and writeback from the 6-bit opcode held in the instruction register.

Parameters:
MEM_WAIT_CYCLES, 0, extra cycles each memory access state (FETCH, MEMRD, MEMWR) is held; range 0..7

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction[31:26] from instruction register; sampled only in DECODE
alu_op  out  2  00 add, 01 subtract, 10 use funct
alu_src_a  out  1  0 PC, 1 register A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted sign-ext imm
pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback: 0 ALUOut, 1 MDR
reg_dst  out  1  dest reg: 0 rt, 1 rd
reg_write  out  1  register file write
state  out  4  current state encoding (debug)
instr_done  out  1  one-cycle pulse in final cycle of each instruction
illegal_op  out  1  one-cycle pulse in DECODE for unsupported opcode

Behaviour:
- States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Reset: state <= FETCH, wait counter <= 0. While reset is high, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done, illegal_op) are 0, and all selects are 0. The first cycle after release is FETCH. Reset overrides any state, including mid-wait.
- Outputs are a Moore decode of state (and wait counter); unlisted outputs are 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00. ir_write=1 and pc_write=1 only on the last hold cycle.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX (macro only)
  - any other -> FETCH, with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1, held; then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
- MEMWR: mem_write=1, i_or_d=1 on every hold cycle; instr_done on the last cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. RWB: reg_write=1, reg_dst=1, instr_done=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- All terminal states, and illegal DECODE, return to FETCH.
- Hold rule: the wait counter clears on entry to a memory state and increments each cycle. The state advances when count == MEM_WAIT_CYCLES, so the state lasts 1+MEM_WAIT_CYCLES cycles.
- Latency with MEM_WAIT_CYCLES=0: R 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles.
- Opcode changes outside DECODE are ignored.

Optional Feature:
MC_ADDI_EN:
- Defined: opcode 001000 takes DECODE->ADDIEX->ADDIWB->FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
- Undefined: ADDIEX/ADDIWB are not built, and 001000 is illegal.

Decomposition:
- Shared package: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_op codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), alu_src_b and pc_source select codes.
- One sub-module, mc_wait_counter: clear/enable counter producing a done flag at MEM_WAIT_CYCLES.

Test Plan:
- reset high 3 cycles, release, opcode=000000, MEM_WAIT_CYCLES=0 -> state 0,1,6,7,0; alu_op 00,00,10; RWB reg_write=1, reg_dst=1, instr_done=1.
- opcode=100011 -> state 0,1,2,3,4; mem_read in FETCH and MEMRD; MEMRD i_or_d=1; MEMWB reg_write=1, mem_to_reg=1.
- MEM_WAIT_CYCLES=2, opcode=101011 -> FETCH 3 cycles with ir_write/pc_write only in the 3rd; MEMWR 3 cycles, mem_write=1 each; instr_done only in the last.
- opcode=000100 -> 0,1,8 with pc_write_cond=1, alu_op=01, pc_source=01; opcode=000010 -> 0,1,9 with pc_write=1, pc_source=10.
- opcode=111111 -> illegal_op=1 in DECODE, next FETCH; no reg_write/mem_write. opcode=001000 -> same without MC_ADDI_EN; 0,1,10,11 with it.
- reset asserted during MEMRD (MEM_WAIT_CYCLES=3, 2nd hold cycle) -> all strobes 0 while high; FETCH on the first cycle after release, with the counter restarted.
